// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator bank.
package acc_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        LOAD = 3'd1,
        ADD  = 3'd2,
        SUB  = 3'd3,
        AND  = 3'd4,
        OR   = 3'd5,
        XOR  = 3'd6,
        CLR  = 3'd7
    } acc_op_e;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned FLG_Z  = 0;
    localparam int unsigned FLG_N  = 1;
    localparam int unsigned FLG_C  = 2;
    localparam int unsigned FLG_V  = 3;

endpackage

// File: rtl/acc_sat_addsub.sv
// Combinational add/subtract with carry/borrow, signed overflow and optional saturation.
module acc_sat_addsub #(
    parameter int unsigned DATA_W = 8,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] y,
    output logic              carry,
    output logic              ovf
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] raw;

    // For subtraction the extra sum bit is the unsigned borrow (a < b).
    always_comb begin
        sum   = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        raw   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
        if (sub) begin
            ovf = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);
        end else begin
            ovf = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
        end
        y = raw;
        // Overflow direction follows the sign of a: negative a can only underflow.
        if (SAT_EN && ovf) begin
            y = a[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/acc_bank.sv
// Accumulator bank: one ALU op per accepted command, single registered result stage.
module acc_bank
    import acc_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_ACC = 4,
    parameter bit          SAT_EN  = 1'b1,
    localparam int unsigned SEL_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  acc_op_e           cmd_op,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [SEL_W-1:0]  res_sel,
    output logic [FLAG_W-1:0] res_flags,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] acc_q [NUM_ACC];

    logic              accept_c;
    logic              sel_ok_c;
    logic [DATA_W-1:0] cur_c;
    logic [DATA_W-1:0] nxt_c;
    logic              carry_c;
    logic              ovf_c;
    logic [FLAG_W-1:0] flags_c;
    logic [DATA_W-1:0] as_y;
    logic              as_carry;
    logic              as_ovf;

    assign cmd_ready = !res_valid || res_ready;
    assign accept_c  = cmd_valid && cmd_ready;
    assign sel_ok_c  = 32'(cmd_sel) < NUM_ACC;
    assign cur_c     = sel_ok_c ? acc_q[cmd_sel] : '0;
    assign rd_data   = (32'(rd_sel) < NUM_ACC) ? acc_q[rd_sel] : '0;

    acc_sat_addsub #(
        .DATA_W (DATA_W),
        .SAT_EN (SAT_EN)
    ) u_addsub (
        .a     (cur_c),
        .b     (cmd_data),
        .sub   (cmd_op == SUB),
        .y     (as_y),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    // Op mux and flag generation; out-of-range targets yield a zero beat.
    always_comb begin
        nxt_c   = cur_c;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (cmd_op)
            LOAD:     nxt_c = cmd_data;
            ADD, SUB: begin
                nxt_c   = as_y;
                carry_c = as_carry;
                ovf_c   = as_ovf;
            end
            AND:      nxt_c = cur_c & cmd_data;
            OR:       nxt_c = cur_c | cmd_data;
            XOR:      nxt_c = cur_c ^ cmd_data;
            CLR:      nxt_c = '0;
            default:  nxt_c = cur_c;
        endcase
        if (!sel_ok_c) begin
            nxt_c   = '0;
            carry_c = 1'b0;
            ovf_c   = 1'b0;
        end
        flags_c        = '0;
        flags_c[FLG_Z] = (nxt_c == '0);
        flags_c[FLG_N] = nxt_c[DATA_W-1];
        flags_c[FLG_C] = carry_c;
        flags_c[FLG_V] = ovf_c;
    end

    // Accumulator array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_ACC); i++) begin
                acc_q[i] <= '0;
            end
        end else if (accept_c && sel_ok_c) begin
            acc_q[cmd_sel] <= nxt_c;
        end
    end

    // Result stage: reloads on accept, otherwise drains when consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
            res_flags <= '0;
        end else if (accept_c) begin
            res_valid <= 1'b1;
            res_data  <= nxt_c;
            res_sel   <= cmd_sel;
            res_flags <= flags_c;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_bank.sv
// Directed self-checking bench for acc_bank: saturating 4-entry DUT plus wrapping 3-entry DUT.
module tb_acc_bank;
    import acc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    acc_op_e    cmd_op = NOP;
    logic [1:0] cmd_sel = '0;
    logic [7:0] cmd_data = '0;
    logic       res_ready = 1'b1;
    logic [1:0] rd_sel = '0;

    logic       cmd_ready, res_valid;
    logic [7:0] res_data, rd_data;
    logic [1:0] res_sel;
    logic [3:0] res_flags;

    logic       w_cmd_ready, w_res_valid;
    logic [7:0] w_res_data, w_rd_data;
    logic [1:0] w_res_sel;
    logic [3:0] w_res_flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    acc_bank #(.DATA_W(8), .NUM_ACC(4), .SAT_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_sel(res_sel), .res_flags(res_flags), .rd_sel(rd_sel), .rd_data(rd_data)
    );

    acc_bank #(.DATA_W(8), .NUM_ACC(3), .SAT_EN(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
        .res_valid(w_res_valid), .res_ready(res_ready), .res_data(w_res_data),
        .res_sel(w_res_sel), .res_flags(w_res_flags), .rd_sel(rd_sel), .rd_data(w_rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input acc_op_e op, input logic [1:0] sel, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_data  = data;
        #1;
        for (int k = 0; k < 20 && !cmd_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!cmd_ready) chk("issue_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        rd_sel = sel;
        #1;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_res_flags", 32'(res_flags), 32'd0);
        #10;
        rst = 1'b0;
        idle();

        // Basic LOAD / ADD / SUB on sel1
        res_ready = 1'b1;
        issue(LOAD, 2'd1, 8'h10);
        chk("t2_load_valid", 32'(res_valid), 32'd1);
        chk("t2_load_data",  32'(res_data),  32'h10);
        chk("t2_load_sel",   32'(res_sel),   32'd1);
        issue(ADD, 2'd1, 8'h05);
        chk("t2_add_data",   32'(res_data),  32'h15);
        issue(SUB, 2'd1, 8'h15);
        chk("t2_sub_data",   32'(res_data),  32'h00);
        chk("t2_sub_flags",  32'(res_flags), 32'b0001);

        // Saturation vs wrap on sel0
        issue(LOAD, 2'd0, 8'h70);
        issue(ADD, 2'd0, 8'h20);
        chk("t3_sat_pos_data",   32'(res_data),    32'h7F);
        chk("t3_sat_pos_flags",  32'(res_flags),   32'b1000);
        chk("t3_wrap_pos_data",  32'(w_res_data),  32'h90);
        chk("t3_wrap_pos_flags", 32'(w_res_flags), 32'b1010);
        issue(LOAD, 2'd0, 8'h80);
        issue(SUB, 2'd0, 8'h01);
        chk("t3_sat_neg_data",   32'(res_data),    32'h80);
        chk("t3_sat_neg_flags",  32'(res_flags),   32'b1010);
        chk("t3_wrap_neg_data",  32'(w_res_data),  32'h7F);
        chk("t3_wrap_neg_flags", 32'(w_res_flags), 32'b1000);
        issue(LOAD, 2'd0, 8'h80);
        issue(SUB, 2'd0, 8'hFF);
        chk("t3_sub_m1_data",    32'(res_data),    32'h81);
        chk("t3_sub_m1_flags",   32'(res_flags),   32'b0110);
        issue(LOAD, 2'd3, 8'hF0);
        issue(ADD, 2'd3, 8'h20);
        chk("t3_carry_data",     32'(res_data),    32'h10);
        chk("t3_carry_flags",    32'(res_flags),   32'b0100);

        // Backpressure on sel3
        idle();
        chk("t4_drained", 32'(res_valid), 32'd0);
        res_ready = 1'b0;
        issue(LOAD, 2'd3, 8'h33);
        chk("t4_first_data", 32'(res_data), 32'h33);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        cmd_sel   = 2'd3;
        cmd_data  = 8'h01;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_hold_ready", 32'(cmd_ready), 32'd0);
            chk("t4_hold_valid", 32'(res_valid), 32'd1);
            chk("t4_hold_data",  32'(res_data),  32'h33);
            rd_chk("t4_hold_acc", 2'd3, 8'h33);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        #1;
        chk("t4_release_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("t4_next_valid", 32'(res_valid), 32'd1);
        chk("t4_next_data",  32'(res_data),  32'h34);
        chk("t4_next_sel",   32'(res_sel),   32'd3);
        idle();
        chk("t4_consumed_valid", 32'(res_valid), 32'd0);
        chk("t4_consumed_hold",  32'(res_data),  32'h34);

        // Streaming 8 ADDs to sel2, one per cycle
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        cmd_sel   = 2'd2;
        cmd_data  = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("t5_ready", 32'(cmd_ready), 32'd1);
            @(posedge clk); #1;
            chk("t5_valid", 32'(res_valid), 32'd1);
            chk("t5_data",  32'(res_data),  32'(i));
        end
        cmd_valid = 1'b0;
        rd_chk("t5_acc0", 2'd0, 8'h81);
        rd_chk("t5_acc1", 2'd1, 8'h00);
        rd_chk("t5_acc2", 2'd2, 8'h08);
        rd_chk("t5_acc3", 2'd3, 8'h34);

        // Independence, NOP and out-of-range select
        issue(LOAD, 2'd0, 8'hAA);
        issue(LOAD, 2'd3, 8'h55);
        issue(XOR, 2'd0, 8'hFF);
        chk("t6_xor_data", 32'(res_data), 32'h55);
        rd_chk("t6_acc0", 2'd0, 8'h55);
        rd_chk("t6_acc3", 2'd3, 8'h55);
        issue(NOP, 2'd0, 8'h99);
        chk("t6_nop_data",  32'(res_data),  32'h55);
        chk("t6_nop_flags", 32'(res_flags), 32'b0000);
        issue(ADD, 2'd3, 8'h12);
        chk("t6_main_sel3",   32'(res_data),    32'h67);
        chk("t6_oor_valid",   32'(w_res_valid), 32'd1);
        chk("t6_oor_data",    32'(w_res_data),  32'h00);
        chk("t6_oor_flags",   32'(w_res_flags), 32'b0001);
        chk("t6_oor_sel",     32'(w_res_sel),   32'd3);
        rd_sel = 2'd0; #1;
        chk("t6_oor_acc0", 32'(w_rd_data), 32'h55);
        rd_sel = 2'd1; #1;
        chk("t6_oor_acc1", 32'(w_rd_data), 32'h00);
        rd_sel = 2'd2; #1;
        chk("t6_oor_acc2", 32'(w_rd_data), 32'h08);

        // Asynchronous reset with a result pending
        idle();
        res_ready = 1'b0;
        issue(LOAD, 2'd1, 8'h42);
        chk("t1_pending_valid", 32'(res_valid), 32'd1);
        chk("t1_pending_ready", 32'(cmd_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_valid", 32'(res_valid), 32'd0);
        chk("t1_ready", 32'(cmd_ready), 32'd1);
        chk("t1_data",  32'(res_data),  32'd0);
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            chk("t1_acc", 32'(rd_data), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
